imem_loader: RTL
================

# imem_loader

Writes a program into the instruction memory that the `taylor` fetch stage reads. Accepts a byte stream over a valid/ready handshake, packs each four bytes big-endian into a 32-bit instruction, and writes the instructions to consecutive word addresses starting at 0. Holds the core while loading, so no fetch sees a partially written program.

## Interface
- `ADDR_WIDTH`, 8, instruction-memory word-address width; depth = 2**ADDR_WIDTH words.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- `word_count`  in  ADDR_WIDTH+1  number of words to load; sampled with `start`; values above depth are clamped to depth.
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `im_we`  out  1  one-cycle instruction-memory write strobe.
- `im_addr`  out  ADDR_WIDTH  word address of the write.
- `im_wdata`  out  32  instruction to write.
- `core_hold`  out  1  core must stall fetch, with PC held at 0, while high.
- `busy`  out  1  load in progress.
- `done`  out  1  sticky completion flag; cleared by the next accepted `start` or by `rst`.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE/DONE + `start`:
  - If the clamped count is 0, go to DONE.
  - Otherwise go to LOAD, clear the byte counter (2 bits) and address counter, and latch the count.
- LOAD: `in_ready`=1. A byte is accepted when `in_valid && in_ready`.
  - 1st byte → bits 31:24, 2nd → 23:16, 3rd → 15:8, 4th → 7:0. Example: bytes 20 10 00 05 → 32'h20100005.
- On the 4th accepted byte:
  - Register `im_wdata` = packed word and `im_addr` = address counter.
  - Pulse `im_we`.
  - Increment the address counter.
  - If this was the last word, go to DONE.
- `busy` = `core_hold` = (state == LOAD). `done` = (state == DONE).
- `start` during LOAD is ignored.
- The address never wraps, because the count is clamped to depth. The last possible address is depth−1.
- `rst` at any time:
  - State goes to IDLE and all outputs return to reset values.
  - A partially packed word is discarded and not written.
  - Words already written stay in memory; the loader never clears memory.

## Timing
- Reset values: `in_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `core_hold`=0, `busy`=0, `done`=0.
- `start` at cycle T:
  - `busy`/`in_ready` are high from T+1.
  - A byte presented at T is not accepted, because `in_ready` is still 0.
- 4th byte of a word accepted at cycle N:
  - `im_we`=1 at N+1, for exactly one cycle, with `im_addr`/`im_wdata` valid in the same cycle.
  - `im_addr`/`im_wdata` hold their values afterwards.
- Back-to-back words: `in_ready` stays high through the write cycle. Maximum throughput is 1 byte/cycle; a full word can be written every 4 cycles.
- Last word accepted at N: at N+1 `done`=1 and `busy`=`core_hold`=`in_ready`=0, in the same cycle as the final `im_we`.
- `word_count`=0 with `start` at T: `done`=1 at T+1; `busy` never rises and no write occurs.
- Gaps in `in_valid` stall packing with no state loss.

## Structure
- Shared package `imem_pkg`:
  - `WORD_BYTES`=4.
  - State encoding `IML_IDLE`/`IML_LOAD`/`IML_DONE`.
  - Default `ADDR_WIDTH`, also used by the instruction memory.
- One sub-module, `byte_packer`:
  - 8→32 big-endian shift register with a 2-bit byte counter and a `word_valid` pulse on the 4th byte.
  - Clears on `rst` or on the load-start pulse.
- Top level holds the FSM, the address/count counters and the write-port registers.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid`=1 → all outputs 0, no `im_we`.
- Basic load: `start`, `word_count`=2, bytes 20 10 00 05 01 2A 48 20 with `in_valid` held high →
  - writes (0, 32'h20100005), then (1, 32'h012A4820);
  - `im_we` pulses 4 cycles apart;
  - `done`=1 with the second write; `core_hold` falls in the same cycle.
- Bubbles: same stream as the basic load, with `in_valid` low on alternate cycles and 3 idle cycles mid-word → identical writes and data. `start` pulsed during LOAD has no effect.
- Zero count: `start`, `word_count`=0 → `done` at T+1, `busy` never high, no writes, `in_ready` stays 0.
- Reset mid-word: `word_count`=3, send 20 10 00 05 8C 0A, then `rst` → no second write, state IDLE. A new `start` with 4 bytes 34 E7 00 FF writes (0, 32'h34E700FF).
- Clamp: `ADDR_WIDTH`=8, `word_count`=300 → exactly 256 writes, last `im_addr`=255, no address 0 rewrite; `done` after write 256.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the memory it fills.
package imem_pkg;

  localparam int unsigned WORD_BYTES      = 4;
  localparam int unsigned IMEM_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IML_IDLE = 2'd0,
    IML_LOAD = 2'd1,
    IML_DONE = 2'd2
  } iml_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Control, byte-stream and instruction-memory write signals of the loader.
interface imem_loader_if
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH
);

  logic                  start;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  im_we;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic [31:0]           im_wdata;
  logic                  core_hold;
  logic                  busy;
  logic                  done;

  // Host / byte source side.
  modport master (
    output start, word_count, in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata, core_hold, busy, done
  );

  // Loader side.
  modport slave (
    input  start, word_count, in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata, core_hold, busy, done
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs four stream bytes big-endian into one 32-bit word.
module byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_accept,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shreg;
  logic [1:0]  cnt;

  // Shift in accepted bytes; a clear drops any partially packed word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (in_accept) begin
      shreg <= {shreg[15:0], in_byte};
      cnt   <= cnt + 2'd1;
    end
  end

  // The fourth byte completes the word combinationally so the caller can
  // register it in the same edge that accepts that byte.
  always_comb begin
    word       = {shreg, in_byte};
    word_valid = in_accept && (cnt == 2'(WORD_BYTES - 1));
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-wise program into instruction memory while holding the core.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH
)(
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  iml_state_t state, next_state;

  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   addr_cnt;
  logic [ADDR_WIDTH:0]   addr_next;
  logic [ADDR_WIDTH:0]   clamped;
  logic                  start_acc;
  logic                  load;
  logic                  accept;
  logic [31:0]           word;
  logic                  word_valid;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_acc),
    .in_accept  (accept),
    .in_byte    (bus.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IML_IDLE;
    else     state <= next_state;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    next_state = state;
    start_acc  = 1'b0;
    clamped    = (bus.word_count > DEPTH) ? DEPTH : bus.word_count;
    load       = (state == IML_LOAD);
    accept     = bus.in_valid && load;
    addr_next  = addr_cnt + ONE;
    unique case (state)
      IML_IDLE, IML_DONE: begin
        if (bus.start) begin
          start_acc  = 1'b1;
          next_state = (clamped == '0) ? IML_DONE : IML_LOAD;
        end
      end
      IML_LOAD: begin
        if (word_valid && (addr_next == count_q)) next_state = IML_DONE;
      end
      default: next_state = IML_IDLE;
    endcase
    bus.in_ready  = load;
    bus.busy      = load;
    bus.core_hold = load;
    bus.done      = (state == IML_DONE);
    bus.im_we     = we_q;
    bus.im_addr   = addr_q;
    bus.im_wdata  = wdata_q;
  end

  // Count latch, address counter and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      addr_cnt <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      we_q <= 1'b0;
      if (start_acc) begin
        count_q  <= clamped;
        addr_cnt <= '0;
      end
      if (word_valid) begin
        we_q     <= 1'b1;
        addr_q   <= addr_cnt[ADDR_WIDTH-1:0];
        wdata_q  <= word;
        addr_cnt <= addr_next;
      end
    end
  end

endmodule
